// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
//
// Sequential 3-digit BCD to 12-bit binary converter using reverse double-dabble.
// One shift/correct iteration is performed per clock; a conversion takes 12
// iterations. Digits above 9 are optionally flagged instead of converted.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   conversion request, only sampled while idle
//   hundreds in   4   BCD hundreds digit (sampled on the accepting edge)
//   tens     in   4   BCD tens digit
//   ones     in   4   BCD ones digit
//   binary   out 12   result, held until the next conversion completes
//   busy     out  1   high while iterations are running
//   done     out  1   one-cycle pulse, binary/error valid
//   error    out  1   last accepted request contained an invalid digit
// -----------------------------------------------------------------------------
module bcd_to_binary_seq #(
    parameter int DIGIT_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    output logic [11:0] binary,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] LAST_ITER = 4'd11;

    logic [1:0]  r_state;
    logic [11:0] r_bcd;
    logic [11:0] r_bin;
    logic [3:0]  r_count;
    logic [11:0] r_binary;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic [23:0] w_shift;
    logic [11:0] w_bcd_next;
    logic [11:0] w_bin_next;
    logic        w_invalid;

    // After a right shift, a BCD nibble that reached 8 or more received a
    // carried-in "ten" worth 8 from the digit above; a decimal ten is only
    // worth 5 at this position, so 3 is removed.
    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    always_comb begin
        w_shift    = {r_bcd, r_bin} >> 1;
        w_bin_next = w_shift[11:0];
        w_bcd_next = {fix_digit(w_shift[23:20]),
                      fix_digit(w_shift[19:16]),
                      fix_digit(w_shift[15:12])};
        w_invalid  = (DIGIT_CHECK != 0) &&
                     ((hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bcd    <= '0;
            r_bin    <= '0;
            r_count  <= '0;
            r_binary <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bcd <= {hundreds, tens, ones};
                        r_bin <= '0;
                        if (w_invalid) begin
                            // Skip the iterations entirely; report on the next cycle.
                            r_binary <= '0;
                            r_error  <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_error <= 1'b0;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_bin   <= w_bin_next;
                    r_count <= r_count + 4'd1;
                    if (r_count == LAST_ITER) begin
                        // Result register only changes here, so a previous
                        // result stays visible for the whole conversion.
                        r_binary <= w_bin_next;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign binary = r_binary;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [11:0] binary;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec;
    int n_err;
    int n_done;
    logic [12:0] exp_q[$];

    bcd_to_binary_seq #(.DIGIT_CHECK(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected {error, binary}.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            logic [12:0] e;
            n_done++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got binary=0x%0h error=%0b, expected no done", binary, error);
            end else begin
                e = exp_q.pop_front();
                if ({error, binary} !== e) begin
                    n_err++;
                    $display("FAIL result: got error=%0b binary=0x%0h, expected error=%0b binary=0x%0h",
                             error, binary, e[12], e[11:0]);
                end
            end
        end
    end

    // Issue one request and measure latency / busy cycles up to done.
    task automatic do_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [11:0] eb, input logic ee,
                           input int elat, input int ebusy, input string name);
        int lat;
        int busyc;
        @(negedge clk);
        hundreds = h; tens = t; ones = o; start = 1'b1;
        exp_q.push_back({ee, eb});
        @(negedge clk);
        start = 1'b0;
        hundreds = 4'hF; tens = 4'hF; ones = 4'hF;
        lat = 1; busyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busyc++;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_busy_cycles"}, busyc, ebusy);
        @(negedge clk);
        check({name, "_done_width"}, int'(done), 0);
    endtask

    initial begin
        int t_done[3];
        int cyc;
        int k;
        int nd0;

        n_vec = 0; n_err = 0; n_done = 0;
        start = 1'b0; hundreds = '0; tens = '0; ones = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_binary", int'(binary), 0);
        check("reset_busy",   int'(busy),   0);
        check("reset_done",   int'(done),   0);
        check("reset_error",  int'(error),  0);
        rst_n = 1'b1;

        // 1: 999
        do_conv(4'd9, 4'd9, 4'd9, 12'h3E7, 1'b0, 13, 12, "c999");

        // 2: sequence
        do_conv(4'd0, 4'd0, 4'd0, 12'h000, 1'b0, 13, 12, "c000");
        do_conv(4'd1, 4'd2, 4'd3, 12'h07B, 1'b0, 13, 12, "c123");
        do_conv(4'd2, 4'd5, 4'd5, 12'h0FF, 1'b0, 13, 12, "c255");

        // 3: invalid digit, then valid
        do_conv(4'd1, 4'hA, 4'd3, 12'h000, 1'b1, 1, 0, "c1A3");
        do_conv(4'd0, 4'd4, 4'd2, 12'h02A, 1'b0, 13, 12, "c042");

        // 4: start pulsed mid-conversion with different digits is ignored
        nd0 = n_done;
        @(negedge clk);
        hundreds = 4'd9; tens = 4'd9; ones = 4'd9; start = 1'b1;
        exp_q.push_back({1'b0, 12'h3E7});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        hundreds = 4'd1; tens = 4'd1; ones = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("ignore_done_count", n_done - nd0, 1);
        check("ignore_binary", int'(binary), 12'h3E7);

        // 5: reset in the middle of a 500 conversion
        nd0 = n_done;
        @(negedge clk);
        hundreds = 4'd5; tens = 4'd0; ones = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_binary", int'(binary), 0);
        check("midrst_busy",   int'(busy),   0);
        check("midrst_done",   int'(done),   0);
        check("midrst_error",  int'(error),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_no_done", n_done - nd0, 0);
        do_conv(4'd5, 4'd0, 4'd0, 12'h1F4, 1'b0, 13, 12, "c500");

        // 6: start held high -> back-to-back conversions every 14 cycles
        @(negedge clk);
        repeat (3) exp_q.push_back({1'b0, 12'h063});
        hundreds = 4'd0; tens = 4'd9; ones = 4'd9; start = 1'b1;
        cyc = 0; k = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                t_done[k] = cyc;
                k++;
                if (k == 3) start = 1'b0;
            end
        end
        check("held_done_count", k, 3);
        if (k == 3) begin
            check("held_period_1", t_done[1] - t_done[0], 14);
            check("held_period_2", t_done[2] - t_done[1], 14);
        end
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
